// File: rtl/drive_pkg.sv
// Shared drive definitions: keypad codes, one-hot motor commands,
// telemetry status encoding and the command filter state enum.
package drive_pkg;

    localparam logic [7:0] KEY_FWD   = 8'h02;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_BRAKE = 8'h05;
    localparam logic [7:0] KEY_RIGHT = 8'h06;
    localparam logic [7:0] KEY_BACK  = 8'h08;

    localparam logic [7:0] CMD_NONE  = 8'h00;
    localparam logic [7:0] CMD_FWD   = 8'h02;
    localparam logic [7:0] CMD_LEFT  = 8'h08;
    localparam logic [7:0] CMD_BRAKE = 8'h10;
    localparam logic [7:0] CMD_RIGHT = 8'h20;
    localparam logic [7:0] CMD_BACK  = 8'h80;

    localparam logic [2:0] STAT_NONE  = 3'd0;
    localparam logic [2:0] STAT_FWD   = 3'd1;
    localparam logic [2:0] STAT_LEFT  = 3'd2;
    localparam logic [2:0] STAT_BRAKE = 3'd3;
    localparam logic [2:0] STAT_RIGHT = 3'd4;
    localparam logic [2:0] STAT_BACK  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BLOCK  = 2'd2
    } drive_state_t;

    // Keypad key to one-hot drive command; unknown keys give CMD_NONE.
    function automatic logic [7:0] key_to_cmd(input logic [7:0] key);
        case (key)
            KEY_FWD:   return CMD_FWD;
            KEY_LEFT:  return CMD_LEFT;
            KEY_BRAKE: return CMD_BRAKE;
            KEY_RIGHT: return CMD_RIGHT;
            KEY_BACK:  return CMD_BACK;
            default:   return CMD_NONE;
        endcase
    endfunction

    // One-hot drive command to telemetry status code.
    function automatic logic [2:0] cmd_to_stat(input logic [7:0] cmd);
        case (cmd)
            CMD_FWD:   return STAT_FWD;
            CMD_LEFT:  return STAT_LEFT;
            CMD_BRAKE: return STAT_BRAKE;
            CMD_RIGHT: return STAT_RIGHT;
            CMD_BACK:  return STAT_BACK;
            default:   return STAT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/obstacle_monitor.sv
// Obstacle flag with release hysteresis, updated on each distance strobe.
// near_next exposes the value near will take at the next edge so a frame
// accepted in the same cycle as a strobe sees the fresh obstacle state.
module obstacle_monitor #(
    parameter int STOP_CM = 20,
    parameter int HYST_CM = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] dist_cm,
    input  logic       dist_valid,
    output logic       near,
    output logic       near_next
);

    localparam logic [7:0] STOP_V    = 8'(STOP_CM);
    localparam logic [7:0] RELEASE_V = 8'(STOP_CM + HYST_CM);

    // Set below the stop threshold, clear at/above release or on no echo.
    always_comb begin
        near_next = near;
        if (dist_valid) begin
            if (dist_cm != 8'd0 && dist_cm < STOP_V) begin
                near_next = 1'b1;
            end else if (dist_cm == 8'd0 || dist_cm >= RELEASE_V) begin
                near_next = 1'b0;
            end
        end
    end

    // Obstacle flag register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            near <= 1'b0;
        end else begin
            near <= near_next;
        end
    end

endmodule

// File: rtl/drive_cmd_filter.sv
// Validates NEC frames, maps keys to one-hot drive commands, holds each
// command for a dead-man window and brakes forward motion near obstacles.
//
// state     | meaning
// ST_IDLE   | no command, motor released
// ST_ACTIVE | latched command driven until the hold timer expires
// ST_BLOCK  | forward requested but obstacle present, brake driven
module drive_cmd_filter
    import drive_pkg::*;
#(
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int STOP_CM     = 20,
    parameter int HYST_CM     = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ir_ready,
    input  logic [31:0] ir_data,
    input  logic [7:0]  dist_cm,
    input  logic        dist_valid,
    output logic [7:0]  cmd,
    output logic [2:0]  cmd_stat,
    output logic        blocked,
    output logic        near,
    output logic [7:0]  err_cnt
);

    localparam int            TW        = $clog2(HOLD_CYCLES);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);

    drive_state_t  state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [7:0]    cmd_lat, cmd_lat_d;
    logic [7:0]    err_d;
    logic [7:0]    cmd_d;
    logic          ir_ready_q;
    logic          near_next;

    logic [7:0]    key;
    logic [7:0]    key_cmd;
    logic          accept;
    logic          frame_ok;
    logic          take_frame;
    logic          expired;
    logic          unused_addr;

    assign key         = ir_data[23:16];
    assign key_cmd     = key_to_cmd(key);
    assign accept      = ir_ready && !ir_ready_q;
    assign frame_ok    = (ir_data[31:24] == ~key);
    assign take_frame  = accept && frame_ok;
    assign expired     = (timer == '0);
    assign unused_addr = ^ir_data[15:0];

    obstacle_monitor #(
        .STOP_CM (STOP_CM),
        .HYST_CM (HYST_CM)
    ) u_obstacle_monitor (
        .clk        (clk),
        .rst_n      (rst_n),
        .dist_cm    (dist_cm),
        .dist_valid (dist_valid),
        .near       (near),
        .near_next  (near_next)
    );

    // Next state, latched command, hold timer, error count and outputs.
    always_comb begin
        state_d   = state;
        cmd_lat_d = cmd_lat;
        timer_d   = expired ? timer : timer - 1'b1;
        err_d     = err_cnt;

        if (accept && !frame_ok && err_cnt != 8'hFF) begin
            err_d = err_cnt + 8'd1;
        end

        if (take_frame) begin
            if (key_cmd == CMD_NONE) begin
                state_d = ST_IDLE;
            end else begin
                cmd_lat_d = key_cmd;
                timer_d   = HOLD_LOAD;
                // Frame decision sees the obstacle state including a same-cycle strobe.
                state_d   = (key_cmd == CMD_FWD && near_next) ? ST_BLOCK : ST_ACTIVE;
            end
        end else begin
            case (state)
                ST_ACTIVE: begin
                    if (expired) begin
                        state_d = ST_IDLE;
                    end else if (cmd_lat == CMD_FWD && near) begin
                        state_d = ST_BLOCK;
                    end
                end
                ST_BLOCK: begin
                    // Obstacle clearing never resumes forward on its own.
                    if (!near || expired) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        case (state_d)
            ST_ACTIVE: cmd_d = cmd_lat_d;
            ST_BLOCK:  cmd_d = CMD_BRAKE;
            default:   cmd_d = CMD_NONE;
        endcase
    end

    // State, timer and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            timer      <= '0;
            cmd_lat    <= CMD_NONE;
            ir_ready_q <= 1'b0;
            err_cnt    <= 8'd0;
            cmd        <= CMD_NONE;
            cmd_stat   <= STAT_NONE;
            blocked    <= 1'b0;
        end else begin
            state      <= state_d;
            timer      <= timer_d;
            cmd_lat    <= cmd_lat_d;
            ir_ready_q <= ir_ready;
            err_cnt    <= err_d;
            cmd        <= cmd_d;
            cmd_stat   <= cmd_to_stat(cmd_d);
            blocked    <= (state_d == ST_BLOCK);
        end
    end

endmodule

// File: tb/tb_drive_cmd_filter.sv
// Directed bench for drive_cmd_filter with a 100-cycle hold window.
module tb_drive_cmd_filter;

    localparam int HOLD = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ir_ready;
    logic [31:0] ir_data;
    logic [7:0]  dist_cm;
    logic        dist_valid;
    logic [7:0]  cmd;
    logic [2:0]  cmd_stat;
    logic        blocked;
    logic        near;
    logic [7:0]  err_cnt;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] F_FWD   = 32'hFD02_00FF;
    localparam logic [31:0] F_LEFT  = 32'hFB04_00FF;
    localparam logic [31:0] F_RIGHT = 32'hF906_00FF;
    localparam logic [31:0] F_UNMAP = 32'hF609_00FF;
    localparam logic [31:0] F_BAD   = 32'h1202_00FF;

    drive_cmd_filter #(
        .HOLD_CYCLES (HOLD),
        .STOP_CM     (20),
        .HYST_CM     (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ir_ready   (ir_ready),
        .ir_data    (ir_data),
        .dist_cm    (dist_cm),
        .dist_valid (dist_valid),
        .cmd        (cmd),
        .cmd_stat   (cmd_stat),
        .blocked    (blocked),
        .near       (near),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accept cycle; outputs reflect the frame when this returns.
    task automatic send_frame(input logic [31:0] d);
        ir_data  = d;
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
    endtask

    // One distance strobe; near reflects it when this returns.
    task automatic strobe(input logic [7:0] d);
        dist_cm    = d;
        dist_valid = 1'b1;
        tick();
        dist_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [7:0] c, input logic [2:0] s, input logic b);
        check_val({tag, "_cmd"}, 32'(cmd), 32'(c));
        check_val({tag, "_stat"}, 32'(cmd_stat), 32'(s));
        check_val({tag, "_blk"}, 32'(blocked), 32'(b));
    endtask

    initial begin
        rst_n      = 1'b0;
        ir_ready   = 1'b0;
        ir_data    = '0;
        dist_cm    = '0;
        dist_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check_out("reset", 8'h00, 3'd0, 1'b0);
        check_val("reset_near", 32'(near), 32'd0);
        check_val("reset_err", 32'(err_cnt), 32'd0);

        // Basic hold: non-zero for exactly HOLD cycles.
        send_frame(F_FWD);
        check_out("fwd", 8'h02, 3'd1, 1'b0);
        repeat (HOLD - 1) tick();
        check_val("hold_last", 32'(cmd), 32'h02);
        tick();
        check_val("hold_end", 32'(cmd), 32'h00);

        // Retransmit 60 cycles after the first accept extends the window.
        tick();
        send_frame(F_FWD);
        repeat (59) tick();
        check_val("retx_pre", 32'(cmd), 32'h02);
        send_frame(F_FWD);
        repeat (HOLD - 1) tick();
        check_val("retx_last", 32'(cmd), 32'h02);
        tick();
        check_val("retx_end", 32'(cmd), 32'h00);

        // Bad complement in ACTIVE: command and timer unaffected.
        tick();
        send_frame(F_FWD);
        tick();
        send_frame(F_BAD);
        check_val("bad_cmd", 32'(cmd), 32'h02);
        check_val("bad_err", 32'(err_cnt), 32'd1);
        repeat (HOLD - 3) tick();
        check_val("bad_hold_last", 32'(cmd), 32'h02);
        tick();
        check_val("bad_hold_end", 32'(cmd), 32'h00);

        for (int i = 0; i < 299; i++) begin
            tick();
            send_frame(F_BAD);
        end
        check_val("err_sat", 32'(err_cnt), 32'd255);
        check_val("err_sat_cmd", 32'(cmd), 32'h00);

        // Obstacle handling while driving forward.
        tick();
        send_frame(F_FWD);
        strobe(8'd15);
        check_val("near_set", 32'(near), 32'd1);
        check_val("near_lag_cmd", 32'(cmd), 32'h02);
        tick();
        check_out("block", 8'h10, 3'd3, 1'b1);
        strobe(8'd22);
        tick();
        check_val("hyst_near", 32'(near), 32'd1);
        check_out("hyst", 8'h10, 3'd3, 1'b1);
        strobe(8'd25);
        check_val("release_near", 32'(near), 32'd0);
        tick();
        check_out("release", 8'h00, 3'd0, 1'b0);
        strobe(8'd15);
        strobe(8'd0);
        check_val("noecho_near", 32'(near), 32'd0);

        // Key handling with an obstacle present.
        strobe(8'd15);
        send_frame(F_RIGHT);
        check_out("near_right", 8'h20, 3'd4, 1'b0);
        tick();
        send_frame(F_FWD);
        check_out("near_fwd", 8'h10, 3'd3, 1'b1);
        tick();
        send_frame(F_UNMAP);
        check_out("near_unmap", 8'h00, 3'd0, 1'b0);

        // Strobe in the accept cycle decides the frame.
        strobe(8'd30);
        tick();
        dist_cm    = 8'd10;
        dist_valid = 1'b1;
        send_frame(F_FWD);
        dist_valid = 1'b0;
        check_out("same_cycle", 8'h10, 3'd3, 1'b1);
        tick();
        send_frame(F_UNMAP);
        strobe(8'd30);

        // Level held high gives a single accept.
        tick();
        ir_data  = F_FWD;
        ir_ready = 1'b1;
        tick();
        check_val("held_first", 32'(cmd), 32'h02);
        repeat (999) tick();
        check_val("held_end", 32'(cmd), 32'h00);
        ir_ready = 1'b0;
        tick();

        // Synchronous reset mid-ACTIVE.
        send_frame(F_LEFT);
        strobe(8'd15);
        check_out("pre_rst", 8'h08, 3'd2, 1'b0);
        rst_n = 1'b0;
        tick();
        check_out("rst", 8'h00, 3'd0, 1'b0);
        check_val("rst_near", 32'(near), 32'd0);
        check_val("rst_err", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
